// File: rtl/pipmem_rv32.sv
// Purpose: RV32I memory-access stage; store lane steering, load extract/extend, word-addressed req/ack port.
// Latency: non-memory results 1 cycle; memory ops occupy 1 + N cycles (N = BUSY cycles up to and including ack).
// Backpressure: oSTALL holds execute for the whole BUSY period; the request is held until iDMEM_ACK is sampled.
module pipmem_rv32 (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMEM,
  input  logic        iRW,
  input  logic [31:0] iMEMADDR,
  input  logic [31:0] iMEMDATA,
  input  logic [31:0] iDregDATA,
  input  logic [4:0]  iDregADDR,
  input  logic [4:0]  iDecodedOP,
  input  logic [1:0]  iINVALID,
  input  logic        iDMEM_ACK,
  input  logic [31:0] iDMEM_RDATA,
  output logic        oSTALL,
  output logic        oDMEM_REQ,
  output logic        oDMEM_WE,
  output logic [29:0] oDMEM_ADDR,
  output logic [3:0]  oDMEM_BE,
  output logic [31:0] oDMEM_WDATA,
  output logic        oWbEN,
  output logic [4:0]  oWbADDR,
  output logic [31:0] oWbDATA,
  output logic [2:0]  oEXC
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stateT;

  stateT state;
  stateT stateNext;

  // Context of the outstanding memory op, captured on the accept edge
  logic [4:0]  rdLatch;
  logic [4:0]  opLatch;
  logic [1:0]  offLatch;
  logic        loadLatch;

  // Decode results for the instruction presented in IDLE
  logic        isHalf;
  logic        isWord;
  logic        misaligned;
  logic        accept;
  logic        ackDone;

  // Steered store lanes and extracted load value
  logic [3:0]  storeBe;
  logic [31:0] storeData;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;

  // Stall comes straight from the state register so execute never sees a combinational input path
  assign oSTALL = (state == BUSY);

  // Access size decode and alignment check; bit 4 only means LHU for loads
  always_comb begin
    isHalf     = iRW ? (iDecodedOP[1] | iDecodedOP[4]) : iDecodedOP[1];
    isWord     = iDecodedOP[2];
    misaligned = (isHalf & iMEMADDR[0]) | (isWord & (iMEMADDR[1:0] != 2'b00));
    accept     = (state == IDLE) & iMEM & ~misaligned & (iINVALID == 2'b00);
    ackDone    = (state == BUSY) & iDMEM_ACK;
  end

  // Store byte-lane steering: narrow data replicated so any enabled lane carries it; loads enable all lanes
  always_comb begin
    storeBe   = 4'b1111;
    storeData = iMEMDATA;
    if (!iRW) begin
      if (iDecodedOP[0]) begin
        storeBe   = 4'b0001 << iMEMADDR[1:0];
        storeData = {4{iMEMDATA[7:0]}};
      end else if (iDecodedOP[1]) begin
        storeBe   = iMEMADDR[1] ? 4'b1100 : 4'b0011;
        storeData = {2{iMEMDATA[15:0]}};
      end
    end
  end

  // Load extraction at the latched offset, sign- or zero-extended by the latched size
  always_comb begin
    case (offLatch)
      2'd0:    byteSel = iDMEM_RDATA[7:0];
      2'd1:    byteSel = iDMEM_RDATA[15:8];
      2'd2:    byteSel = iDMEM_RDATA[23:16];
      default: byteSel = iDMEM_RDATA[31:24];
    endcase
    halfSel  = offLatch[1] ? iDMEM_RDATA[31:16] : iDMEM_RDATA[15:0];
    loadData = iDMEM_RDATA;
    if (opLatch[0]) begin
      loadData = {{24{byteSel[7]}}, byteSel};
    end else if (opLatch[3]) begin
      loadData = {24'd0, byteSel};
    end else if (opLatch[1]) begin
      loadData = {{16{halfSel[15]}}, halfSel};
    end else if (opLatch[4]) begin
      loadData = {16'd0, halfSel};
    end else if (opLatch[2]) begin
      loadData = iDMEM_RDATA;
    end
  end

  // Next-state logic: IDLE -> BUSY on a legal memory op, BUSY -> IDLE when the ack is sampled
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = BUSY;
      BUSY:    if (iDMEM_ACK) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Memory port: launched on accept, held stable through BUSY, dropped on the ack edge or on reset
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDMEM_REQ   <= 1'b0;
      oDMEM_WE    <= 1'b0;
      oDMEM_ADDR  <= 30'd0;
      oDMEM_BE    <= 4'd0;
      oDMEM_WDATA <= 32'd0;
    end else if (accept) begin
      oDMEM_REQ   <= 1'b1;
      oDMEM_WE    <= ~iRW;
      oDMEM_ADDR  <= iMEMADDR[31:2];
      oDMEM_BE    <= storeBe;
      oDMEM_WDATA <= storeData;
    end else if (ackDone) begin
      oDMEM_REQ   <= 1'b0;
    end
  end

  // Destination and load shape of the outstanding op, needed when the read word returns
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rdLatch   <= 5'd0;
      opLatch   <= 5'd0;
      offLatch  <= 2'd0;
      loadLatch <= 1'b0;
    end else if (accept) begin
      rdLatch   <= iDregADDR;
      opLatch   <= iDecodedOP;
      offLatch  <= iMEMADDR[1:0];
      loadLatch <= iRW;
    end
  end

  // Writeback and exception outputs: oWbEN pulses once per result and is cleared otherwise
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oWbEN   <= 1'b0;
      oWbADDR <= 5'd0;
      oWbDATA <= 32'd0;
      oEXC    <= 3'd0;
    end else if (state == IDLE) begin
      if (!iMEM) begin
        oWbEN   <= (iDregADDR != 5'd0) && (iINVALID == 2'b00);
        oWbADDR <= iDregADDR;
        oWbDATA <= iDregDATA;
        oEXC    <= {1'b0, iINVALID};
      end else begin
        oWbEN   <= 1'b0;
        oEXC    <= accept ? 3'b000 : {misaligned, iINVALID};
      end
    end else begin
      oWbEN <= ackDone & loadLatch & (rdLatch != 5'd0);
      if (ackDone & loadLatch) begin
        oWbADDR <= rdLatch;
        oWbDATA <= loadData;
      end
    end
  end

endmodule

// File: tb/tb_pipmem_rv32.sv
// Purpose: self-checking bench for pipmem_rv32; directed literal cases then randomized traffic vs a behavioural model.
// Latency: model predicts outputs after every rising edge; outputs compared on the falling edge.
// Backpressure: bench acts as execute stage (advances only after an IDLE edge) and as a randomly slow memory.
module tb_pipmem_rv32;

  logic        iCLK;
  logic        iRST;
  logic        iMEM;
  logic        iRW;
  logic [31:0] iMEMADDR;
  logic [31:0] iMEMDATA;
  logic [31:0] iDregDATA;
  logic [4:0]  iDregADDR;
  logic [4:0]  iDecodedOP;
  logic [1:0]  iINVALID;
  logic        iDMEM_ACK;
  logic [31:0] iDMEM_RDATA;
  logic        oSTALL;
  logic        oDMEM_REQ;
  logic        oDMEM_WE;
  logic [29:0] oDMEM_ADDR;
  logic [3:0]  oDMEM_BE;
  logic [31:0] oDMEM_WDATA;
  logic        oWbEN;
  logic [4:0]  oWbADDR;
  logic [31:0] oWbDATA;
  logic [2:0]  oEXC;

  int checks = 0;
  int errors = 0;

  pipmem_rv32 dut (
    .iCLK(iCLK), .iRST(iRST), .iMEM(iMEM), .iRW(iRW),
    .iMEMADDR(iMEMADDR), .iMEMDATA(iMEMDATA), .iDregDATA(iDregDATA),
    .iDregADDR(iDregADDR), .iDecodedOP(iDecodedOP), .iINVALID(iINVALID),
    .iDMEM_ACK(iDMEM_ACK), .iDMEM_RDATA(iDMEM_RDATA), .oSTALL(oSTALL),
    .oDMEM_REQ(oDMEM_REQ), .oDMEM_WE(oDMEM_WE), .oDMEM_ADDR(oDMEM_ADDR),
    .oDMEM_BE(oDMEM_BE), .oDMEM_WDATA(oDMEM_WDATA), .oWbEN(oWbEN),
    .oWbADDR(oWbADDR), .oWbDATA(oWbDATA), .oEXC(oEXC)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // ---------------- behavioural model ----------------
  // Access width in bytes from the one-hot size code
  function automatic int sizeOf(input logic rw, input logic [4:0] op);
    if (op[2]) return 4;
    if (op[1] || (rw && op[4])) return 2;
    return 1;
  endfunction

  // Loaded register value: n bytes taken at byte offset, sign-extended for LB/LH
  function automatic logic [31:0] loadValue(input logic [31:0] w, input logic [4:0] op, input logic [1:0] off);
    int n;
    logic [31:0] mask;
    logic [31:0] v;
    n = sizeOf(1'b1, op);
    if (n == 4) return w;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (w >> (8 * off)) & mask;
    if ((op[0] || op[1]) && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // Byte enables of an aligned access: n consecutive lanes starting at the byte offset
  function automatic logic [3:0] laneMask(input int n, input logic [1:0] off);
    logic [31:0] m;
    m = ((32'd1 << n) - 32'd1) << off;
    return m[3:0];
  endfunction

  // Write word: narrow data copied into every lane by multiplication
  function automatic logic [31:0] replicate(input int n, input logic [31:0] d);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  logic        mBusy = 1'b0;
  logic        mReq = 1'b0;
  logic        mWe = 1'b0;
  logic [29:0] mAddr = 30'd0;
  logic [3:0]  mBe = 4'd0;
  logic [31:0] mWdata = 32'd0;
  logic        mWbEn = 1'b0;
  logic [4:0]  mWbAddr = 5'd0;
  logic [31:0] mWbData = 32'd0;
  logic [2:0]  mExc = 3'd0;
  logic        pLoad = 1'b0;
  logic [4:0]  pRd = 5'd0;
  logic [4:0]  pOp = 5'd0;
  logic [1:0]  pOff = 2'd0;
  logic        consumed = 1'b0;
  int          mSize = 0;
  logic        mMis = 1'b0;

  // Model of one clock edge: what the stage must show after it
  always @(posedge iCLK) begin
    consumed = 1'b0;
    if (iRST) begin
      mBusy = 1'b0; mReq = 1'b0; mWe = 1'b0; mAddr = 30'd0; mBe = 4'd0; mWdata = 32'd0;
      mWbEn = 1'b0; mWbAddr = 5'd0; mWbData = 32'd0; mExc = 3'd0;
      consumed = 1'b1;
    end else if (!mBusy) begin
      consumed = 1'b1;
      if (!iMEM) begin
        mWbEn   = (iDregADDR != 5'd0) && (iINVALID == 2'b00);
        mWbAddr = iDregADDR;
        mWbData = iDregDATA;
        mExc    = {1'b0, iINVALID};
      end else begin
        mWbEn = 1'b0;
        mSize = sizeOf(iRW, iDecodedOP);
        mMis  = (iMEMADDR % mSize) != 0;
        if (mMis || iINVALID != 2'b00) begin
          mExc = {mMis, iINVALID};
        end else begin
          mExc   = 3'd0;
          mReq   = 1'b1;
          mWe    = !iRW;
          mAddr  = iMEMADDR[31:2];
          mBe    = iRW ? 4'hF : laneMask(mSize, iMEMADDR[1:0]);
          mWdata = replicate(mSize, iMEMDATA);
          mBusy  = 1'b1;
          pLoad  = iRW;
          pRd    = iDregADDR;
          pOp    = iDecodedOP;
          pOff   = iMEMADDR[1:0];
        end
      end
    end else begin
      mWbEn = 1'b0;
      if (iDMEM_ACK) begin
        mReq  = 1'b0;
        mBusy = 1'b0;
        if (pLoad) begin
          mWbEn   = (pRd != 5'd0);
          mWbAddr = pRd;
          mWbData = loadValue(iDMEM_RDATA, pOp, pOff);
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    chk("stall", 32'(oSTALL), 32'(mBusy));
    chk("req", 32'(oDMEM_REQ), 32'(mReq));
    chk("wb_en", 32'(oWbEN), 32'(mWbEn));
    chk("exc", 32'(oEXC), 32'(mExc));
    if (mWbEn) begin
      chk("wb_addr", 32'(oWbADDR), 32'(mWbAddr));
      chk("wb_data", oWbDATA, mWbData);
    end
    if (mReq) begin
      chk("we", 32'(oDMEM_WE), 32'(mWe));
      chk("addr", 32'(oDMEM_ADDR), 32'(mAddr));
      chk("be", 32'(oDMEM_BE), 32'(mBe));
      if (mWe) chk("wdata", oDMEM_WDATA, mWdata);
    end
  endtask

  // One clock: edge happens, then outputs are compared on the falling edge
  task automatic step();
    @(negedge iCLK);
    compareModel();
  endtask

  task automatic setInstr(input logic mem, input logic rw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] dregData, input logic [4:0] rd, input logic [4:0] op,
                          input logic [1:0] inv);
    iMEM = mem; iRW = rw; iMEMADDR = addr; iMEMDATA = data;
    iDregDATA = dregData; iDregADDR = rd; iDecodedOP = op; iINVALID = inv;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_stall"}, 32'(oSTALL), 32'd0);
    chk({tag, "_req"}, 32'(oDMEM_REQ), 32'd0);
    chk({tag, "_we"}, 32'(oDMEM_WE), 32'd0);
    chk({tag, "_addr"}, 32'(oDMEM_ADDR), 32'd0);
    chk({tag, "_be"}, 32'(oDMEM_BE), 32'd0);
    chk({tag, "_wdata"}, oDMEM_WDATA, 32'd0);
    chk({tag, "_wben"}, 32'(oWbEN), 32'd0);
    chk({tag, "_wbaddr"}, 32'(oWbADDR), 32'd0);
    chk({tag, "_wbdata"}, oWbDATA, 32'd0);
    chk({tag, "_exc"}, 32'(oEXC), 32'd0);
  endtask

  // Byte load at 0x1003 acked in the second BUSY cycle
  task automatic loadByteCase(input string tag, input logic [4:0] op, input logic [31:0] expv);
    setInstr(1'b1, 1'b1, 32'h1003, 32'd0, 32'd0, 5'd7, op, 2'b00);
    iDMEM_ACK = 1'b0;
    step();
    setInstr(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00);
    chk({tag, "_req_c1"}, 32'(oDMEM_REQ), 32'd1);
    chk({tag, "_stall_c1"}, 32'(oSTALL), 32'd1);
    chk({tag, "_addr_c1"}, 32'(oDMEM_ADDR), 32'h400);
    chk({tag, "_be_c1"}, 32'(oDMEM_BE), 32'hF);
    step();
    chk({tag, "_req_c2"}, 32'(oDMEM_REQ), 32'd1);
    chk({tag, "_stall_c2"}, 32'(oSTALL), 32'd1);
    chk({tag, "_addr_c2"}, 32'(oDMEM_ADDR), 32'h400);
    iDMEM_ACK = 1'b1;
    iDMEM_RDATA = 32'h80FF_FF00;
    step();
    iDMEM_ACK = 1'b0;
    chk({tag, "_req_done"}, 32'(oDMEM_REQ), 32'd0);
    chk({tag, "_stall_done"}, 32'(oSTALL), 32'd0);
    chk({tag, "_wben"}, 32'(oWbEN), 32'd1);
    chk({tag, "_wbaddr"}, 32'(oWbADDR), 32'd7);
    chk({tag, "_wbdata"}, oWbDATA, expv);
    step();
    chk({tag, "_wben_pulse"}, 32'(oWbEN), 32'd0);
  endtask

  initial begin
    int k;
    logic rw;
    iRST = 1'b1;
    setInstr(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00);
    iDMEM_ACK = 1'b0;
    iDMEM_RDATA = 32'd0;
    step();
    step();
    checkAllZero("reset");
    iRST = 1'b0;

    // Non-memory result
    setInstr(1'b0, 1'b0, 32'd0, 32'd0, 32'h1234, 5'd5, 5'd0, 2'b00);
    step();
    chk("alu_wben", 32'(oWbEN), 32'd1);
    chk("alu_wbaddr", 32'(oWbADDR), 32'd5);
    chk("alu_wbdata", oWbDATA, 32'h1234);
    chk("alu_stall", 32'(oSTALL), 32'd0);

    // Non-memory with exception flag: no writeback, flags registered
    setInstr(1'b0, 1'b0, 32'd0, 32'd0, 32'h9, 5'd5, 5'd0, 2'b01);
    step();
    chk("inv_wben", 32'(oWbEN), 32'd0);
    chk("inv_exc", 32'(oEXC), 32'h1);

    loadByteCase("lb", 5'b00001, 32'hFFFF_FF80);
    loadByteCase("lbu", 5'b01000, 32'h0000_0080);

    // Halfword store, acked in the first BUSY cycle
    setInstr(1'b1, 1'b0, 32'h2002, 32'h0000_ABCD, 32'd0, 5'd0, 5'b00010, 2'b00);
    step();
    setInstr(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00);
    chk("sh_we", 32'(oDMEM_WE), 32'd1);
    chk("sh_be", 32'(oDMEM_BE), 32'hC);
    chk("sh_wdata", oDMEM_WDATA, 32'hABCD_ABCD);
    chk("sh_stall", 32'(oSTALL), 32'd1);
    iDMEM_ACK = 1'b1;
    step();
    iDMEM_ACK = 1'b0;
    chk("sh_req_done", 32'(oDMEM_REQ), 32'd0);
    chk("sh_wben", 32'(oWbEN), 32'd0);
    chk("sh_stall_done", 32'(oSTALL), 32'd0);

    // Misaligned word load
    setInstr(1'b1, 1'b1, 32'h3001, 32'd0, 32'd0, 5'd3, 5'b00100, 2'b00);
    step();
    chk("mis_req", 32'(oDMEM_REQ), 32'd0);
    chk("mis_exc", 32'(oEXC), 32'h4);
    chk("mis_wben", 32'(oWbEN), 32'd0);
    chk("mis_stall", 32'(oSTALL), 32'd0);

    // Reset while BUSY, then a normal load at 0x10
    setInstr(1'b1, 1'b1, 32'h40, 32'd0, 32'd0, 5'd4, 5'b00100, 2'b00);
    step();
    chk("rb_stall", 32'(oSTALL), 32'd1);
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    checkAllZero("rbusy");
    setInstr(1'b1, 1'b1, 32'h10, 32'd0, 32'd0, 5'd9, 5'b00100, 2'b00);
    step();
    setInstr(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00);
    chk("rl_req", 32'(oDMEM_REQ), 32'd1);
    chk("rl_addr", 32'(oDMEM_ADDR), 32'h4);
    iDMEM_ACK = 1'b1;
    iDMEM_RDATA = 32'hCAFE_F00D;
    step();
    iDMEM_ACK = 1'b0;
    chk("rl_wben", 32'(oWbEN), 32'd1);
    chk("rl_wbaddr", 32'(oWbADDR), 32'd9);
    chk("rl_wbdata", oWbDATA, 32'hCAFE_F00D);

    // LH at 0x22 followed by an ADD held during BUSY
    setInstr(1'b1, 1'b1, 32'h22, 32'd0, 32'd0, 5'd10, 5'b00010, 2'b00);
    step();
    setInstr(1'b0, 1'b0, 32'd0, 32'd0, 32'h55, 5'd11, 5'd0, 2'b00);
    step();
    chk("la_busy_wben", 32'(oWbEN), 32'd0);
    chk("la_busy_stall", 32'(oSTALL), 32'd1);
    iDMEM_ACK = 1'b1;
    iDMEM_RDATA = 32'h8001_1234;
    step();
    iDMEM_ACK = 1'b0;
    chk("la_ld_wbaddr", 32'(oWbADDR), 32'd10);
    chk("la_ld_wbdata", oWbDATA, 32'hFFFF_8001);
    step();
    chk("la_add_wben", 32'(oWbEN), 32'd1);
    chk("la_add_wbaddr", 32'(oWbADDR), 32'd11);
    chk("la_add_wbdata", oWbDATA, 32'h55);

    // Randomized traffic: bench is execute (advances after IDLE edges) and a slow memory
    for (int cyc = 0; cyc < 4000; cyc++) begin
      iRST = ($urandom_range(0, 149) == 0);
      if (consumed) begin
        rw = $urandom_range(0, 1);
        if (rw) k = $urandom_range(0, 4);
        else    k = $urandom_range(0, 2);
        iMEM       = $urandom_range(0, 1);
        iRW        = rw;
        iDecodedOP = 5'(1 << k);
        iMEMADDR   = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (k == 2)                iMEMADDR[1:0] = 2'b00;
          else if (k == 1 || k == 4) iMEMADDR[0] = 1'b0;
        end
        iMEMDATA   = $urandom;
        iDregDATA  = $urandom;
        iDregADDR  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        iINVALID   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      if (oDMEM_REQ) iDMEM_ACK = ($urandom_range(0, 2) == 0);
      else           iDMEM_ACK = ($urandom_range(0, 9) == 0);
      iDMEM_RDATA = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipmem_rv32.md
# pipmem_rv32

Memory-access stage of the RV32I pipeline, directly downstream of the execute stage and upstream of register writeback. Drives a word-addressed data-memory port with a req/ack handshake. Performs byte-lane steering for stores and extraction/extension for loads. Stalls the execute stage while a transaction is outstanding. Non-memory results pass to writeback with one-cycle latency.

## Interface
- No parameters.
- iCLK  in  1  clock, rising edge.
- iRST  in  1  synchronous, active-high reset.
- iMEM  in  1  instruction is a memory transaction.
- iRW  in  1  1 = load, 0 = store; valid when iMEM=1.
- iMEMADDR  in  32  effective byte address.
- iMEMDATA  in  32  store data; bits [7:0]/[15:0]/[31:0] are significant.
- iDregDATA  in  32  non-memory result.
- iDregADDR  in  5  destination register; 0 = no destination, driven by upstream for stores and branches.
- iDecodedOP  in  5  one-hot size: loads [0]LB [1]LH [2]LW [3]LBU [4]LHU; stores [0]SB [1]SH [2]SW.
- iINVALID  in  2  exception flags from execute.
- iDMEM_ACK  in  1  memory completes the current request this cycle.
- iDMEM_RDATA  in  32  read word; valid when iDMEM_ACK=1 on a load.
- oSTALL  out  1  execute stage holds its outputs.
- oDMEM_REQ  out  1  request valid.
- oDMEM_WE  out  1  1 = write.
- oDMEM_ADDR  out  30  word address, iMEMADDR[31:2].
- oDMEM_BE  out  4  byte enables.
- oDMEM_WDATA  out  32  lane-steered write data.
- oWbEN  out  1  write oWbDATA to register oWbADDR.
- oWbADDR  out  5  writeback register.
- oWbDATA  out  32  writeback data.
- oEXC  out  3  [1:0] = registered iINVALID; [2] = misaligned data access.

## Operation
- FSM states: IDLE, BUSY. The block accepts inputs only in IDLE. oSTALL = (state==BUSY), decoded from the state register with no combinational input path.
- Misaligned access: (LH|LHU|SH) with addr[0]=1, or (LW|SW) with addr[1:0]≠0.
- IDLE, iMEM=0: next edge sets oWbEN=(iDregADDR≠0 && iINVALID==0), oWbADDR=iDregADDR, oWbDATA=iDregDATA, oEXC={0,iINVALID}.
- IDLE, iMEM=1 with misalignment or iINVALID≠0: no request, oWbEN=0, oEXC[2]=misaligned, oEXC[1:0]=iINVALID. State stays IDLE.
- IDLE, iMEM=1 legal: next edge sets oDMEM_REQ=1, oDMEM_WE=~iRW and drives ADDR/BE/WDATA, sets oWbEN=0 and oEXC=0, enters BUSY. The destination address and load size/offset are latched.
- Store steering:
  - SB: WDATA = byte replicated ×4, BE = 4'b0001<<addr[1:0].
  - SH: WDATA = half replicated ×2, BE = addr[1] ? 1100 : 0011.
  - SW: BE = 1111.
- Load BE = 1111.
- BUSY: REQ/WE/ADDR/BE/WDATA are held stable until iDMEM_ACK=1 is sampled. At that edge REQ drops to 0 and the state returns to IDLE.
  - Load: oWbEN=(latched rd≠0) and oWbDATA = extracted byte/half at the latched offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Store: oWbEN=0.
- iDMEM_ACK is ignored in IDLE.
- oWbEN is a one-cycle pulse per instruction; it is cleared on any cycle without a new result.

## Timing
- Reset values: state=IDLE, oSTALL=0, oDMEM_REQ=0, oDMEM_WE=0, oDMEM_ADDR=0, oDMEM_BE=0, oDMEM_WDATA=0, oWbEN=0, oWbADDR=0, oWbDATA=0, oEXC=0.
- iRST dominates all other inputs. Reset in BUSY abandons the request: REQ drops on the reset edge, and the memory must tolerate this.
- Non-memory latency is 1 cycle. A memory op occupies the stage for 1 + N cycles, where N ≥ 1 is the number of BUSY cycles up to and including the ack. The load result appears on the edge after the ack.
- The execute stage advances on the accept edge and then holds during BUSY. The held instruction is sampled in the first IDLE cycle after the ack, so there is no back-to-back overlap and no holding buffer.

## Test plan
- Non-memory instruction: iDregADDR=5, iDregDATA=0x1234 → next cycle oWbEN=1, oWbADDR=5, oWbDATA=0x1234, oSTALL=0.
- LB at 0x1003, RDATA=0x80FF_FF00, ack after 2 BUSY cycles → REQ held 2 cycles with ADDR=0x400 and BE=1111, oSTALL=1 for those cycles; then oWbDATA=0xFFFF_FF80. The same sequence with LBU gives 0x0000_0080.
- SH at 0x2002 with data 0x0000_ABCD, ack in the first BUSY cycle → WE=1, BE=1100, WDATA=0xABCD_ABCD, oWbEN=0, stage occupied 2 cycles.
- LW at 0x3001 → no REQ, oEXC=3'b100, oWbEN=0, oSTALL stays 0.
- Reset in BUSY, then a load at 0x10 → REQ=0 and all outputs at reset values; the following load completes normally.
- Load followed by ADD: ADD is held during BUSY; load writeback and ADD writeback arrive on consecutive cycles in order.
